// File: rtl/bcd_timer_src.sv
// bcd_timer_src: mm:ss BCD up/down timer with start/pause/clear/preset control
// and a free-running scan phase counter feeding a four-digit display multiplexer.
module bcd_timer_src #(
    parameter int TICK_DIV  = 100000000,
    parameter int SCAN_BITS = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        dir,
    output logic [3:0]  digit3,
    output logic [3:0]  digit2,
    output logic [3:0]  digit1,
    output logic [3:0]  digit0,
    output logic [1:0]  scan_sel,
    output logic        running,
    output logic        done
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3;
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [1:0]           state, state_nx;
    logic [TW-1:0]        tick_cnt;
    logic [SCAN_BITS-1:0] scan_cnt;
    logic [3:0]           dig [4];
    logic [3:0]           ld_dig [4];
    logic [3:0]           start_dig [4];
    logic [3:0]           step_dig [4];
    logic [3:0]           lim;
    logic                 tick, idle_like, do_load, cy, start_zero, step_zero;

    assign tick      = state == RUN && tick_cnt == TICK_LAST;
    assign idle_like = state == IDLE || state == PAUSE;
    assign do_load   = load && idle_like && !clear;

    // Index 0 is seconds ones; odd indices are the tens digits limited to 5.
    always_comb begin
        cy         = 1'b1;
        lim        = 4'd9;
        start_zero = 1'b1;
        step_zero  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lim          = (i % 2 == 1) ? 4'd5 : 4'd9;
            ld_dig[i]    = load_val[4*i +: 4] > lim ? lim : load_val[4*i +: 4];
            start_dig[i] = do_load ? ld_dig[i] : dig[i];
            step_dig[i]  = !cy ? dig[i] :
                           dir ? (dig[i] == 4'd0 ? lim : dig[i] - 4'd1) :
                                 (dig[i] == lim ? 4'd0 : dig[i] + 4'd1);
            cy           = cy && dig[i] == (dir ? 4'd0 : lim);
            start_zero   = start_zero && start_dig[i] == 4'd0;
            step_zero    = step_zero && step_dig[i] == 4'd0;
        end
        // Reaching 00:00 on a down tick wins over a simultaneous pause request.
        state_nx = clear        ? IDLE :
                   idle_like    ? (start_stop ? (dir && start_zero ? DONE : RUN) : state) :
                   state == RUN ? (tick && dir && step_zero ? DONE : start_stop ? PAUSE : RUN) :
                                  DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            scan_cnt <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i < 4; i++) dig[i] <= 4'd0;
        end else begin
            scan_cnt <= scan_cnt + SCAN_BITS'(1);
            state    <= state_nx;
            running  <= state_nx == RUN;
            done     <= state_nx == DONE;
            tick_cnt <= (clear || do_load || tick) ? '0 :
                        state == RUN ? tick_cnt + TW'(1) : tick_cnt;
            for (int i = 0; i < 4; i++)
                dig[i] <= clear ? 4'd0 : do_load ? ld_dig[i] : tick ? step_dig[i] : dig[i];
        end
    end

    assign digit0   = dig[0];
    assign digit1   = dig[1];
    assign digit2   = dig[2];
    assign digit3   = dig[3];
    assign scan_sel = scan_cnt[SCAN_BITS-1:SCAN_BITS-2];
endmodule

// File: tb/tb_bcd_timer_src.sv
// tb_bcd_timer_src: directed plus randomized check of bcd_timer_src against a
// seconds-level behavioural model of the timer.
module tb_bcd_timer_src;
    localparam int TD = 4;
    localparam int SB = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start_stop = 1'b0, clear = 1'b0, load = 1'b0, dir = 1'b0;
    logic [15:0] load_val = '0;
    logic [3:0]  digit3, digit2, digit1, digit0;
    logic [1:0]  scan_sel;
    logic        running, done;

    int vectors = 0, miscompares = 0;
    bit checking = 1'b0;
    // model: state 0 idle, 1 run, 2 pause, 3 done; time held as total seconds
    int m_st = 0, m_sec = 0, m_ph = 0, m_scan = 0;

    bcd_timer_src #(.TICK_DIV(TD), .SCAN_BITS(SB)) dut (
        .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear),
        .load(load), .load_val(load_val), .dir(dir),
        .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
        .scan_sel(scan_sel), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd(int s);
        return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    function automatic int clampd(logic [3:0] v, int lim);
        return int'(v) > lim ? lim : int'(v);
    endfunction

    function automatic logic [19:0] model_out();
        return {bcd(m_sec), 2'((m_scan / 4) % 4), m_st == 1, m_st == 3};
    endfunction

    function automatic logic [19:0] dut_out();
        return {digit3, digit2, digit1, digit0, scan_sel, running, done};
    endfunction

    function automatic logic [15:0] dut_dig();
        return {digit3, digit2, digit1, digit0};
    endfunction

    task automatic check(string name, logic [19:0] got, logic [19:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) if (checking) check("cycle", dut_out(), model_out());

    task automatic step(input bit ss, input bit cl, input bit ld, input logic [15:0] lv, input bit dr);
        int ls;
        #1;
        start_stop = ss; clear = cl; load = ld; load_val = lv; dir = dr;
        ls = (clampd(lv[15:12], 5) * 10 + clampd(lv[11:8], 9)) * 60 +
             clampd(lv[7:4], 5) * 10 + clampd(lv[3:0], 9);
        m_scan++;
        if (cl) begin
            m_st = 0; m_sec = 0; m_ph = 0;
        end else if (m_st == 1) begin
            if (m_ph == TD - 1) begin
                m_ph = 0;
                m_sec = dr ? (m_sec + 3599) % 3600 : (m_sec + 1) % 3600;
                if (dr && m_sec == 0) m_st = 3;
                else if (ss) m_st = 2;
            end else begin
                m_ph++;
                if (ss) m_st = 2;
            end
        end else if (m_st != 3) begin
            if (ld) begin m_sec = ls; m_ph = 0; end
            if (ss) m_st = (dr && m_sec == 0) ? 3 : 1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit dr);
        repeat (n) step(1'b0, 1'b0, 1'b0, 16'h0, dr);
    endtask

    initial begin
        logic [15:0] picks [4];
        logic [15:0] lv;
        bit          dr;
        picks = '{16'h5959, 16'h0001, 16'h0000, 16'h5900};
        repeat (2) @(negedge clk);
        check("reset_state", dut_out(), 20'h0);
        rst_n = 1'b1;
        #1 checking = 1'b1;
        // 1: idle, scan phase advances every 4 clocks
        idle(20, 1'b0);
        check("idle_digits", 20'(dut_dig()), 20'h0);
        check("idle_scan", 20'(scan_sel), 20'd1);
        // 2: count up through a seconds-ones carry
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        check("start_running", 20'({running, done}), 20'b10);
        idle(40, 1'b0);
        check("up_carry", 20'(dut_dig()), 20'h00010);
        // 3: 59:59 wraps to 00:00 while still running
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'h5959, 1'b0);
        check("load_start", 20'(dut_dig()), 20'h05959);
        idle(4, 1'b0);
        check("wrap_digits", 20'(dut_dig()), 20'h0);
        check("wrap_flags", 20'({running, done}), 20'b10);
        // 4: down count to DONE; DONE ignores start and load
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'h0002, 1'b1);
        idle(4, 1'b1);
        check("down_one", 20'(dut_dig()), 20'h00001);
        idle(4, 1'b1);
        check("down_zero", 20'(dut_dig()), 20'h0);
        check("done_flags", 20'({running, done}), 20'b01);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 16'h1234, 1'b1);
        check("done_hold", 20'({dut_dig(), running, done}), 20'b01);
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        check("clear_flags", 20'({dut_dig(), running, done}), 20'b00);
        // 5: pause keeps the partial second
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        idle(6, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        idle(20, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        check("resume_hold", 20'(dut_dig()), 20'h00001);
        idle(1, 1'b0);
        check("resume_tick", 20'(dut_dig()), 20'h00002);
        // 6: clamped preset, then clear beats load and start
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'hF7AB, 1'b0);
        check("clamp", 20'(dut_dig()), 20'h05759);
        step(1'b1, 1'b1, 1'b1, 16'h1234, 1'b0);
        check("clear_prio", 20'({dut_dig(), running, done}), 20'b00);
        // randomized traffic
        dr = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            lv = ($urandom_range(0, 2) == 0) ? picks[$urandom_range(0, 3)] : 16'($urandom);
            if ($urandom_range(0, 39) == 0) dr = ~dr;
            step($urandom_range(0, 7) == 0, $urandom_range(0, 79) == 0,
                 $urandom_range(0, 11) == 0, lv, dr);
        end
        // asynchronous reset in the middle of a run
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        idle(3, 1'b0);
        #2 rst_n = 1'b0;
        checking = 1'b0;
        #1 check("async_reset", dut_out(), 20'h0);
        m_st = 0; m_sec = 0; m_ph = 0; m_scan = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 checking = 1'b1;
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        idle(8, 1'b0);
        check("post_reset", 20'(dut_dig()), 20'h00002);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
